// File: rtl/dwt_pkg.sv
// Shared definitions for the streaming Haar DWT engine.
// - SCALE/SHIFT/ROUND: Q8 approximation of 1/sqrt(2) with round-half-up.
// - MAX_DW/WIDE_W: widest supported sample and the matching product width.
// - pair_t: one assembled sample pair plus its framing flags.
// - sat_to_dw: clamps a wide signed value into a DW-bit signed range.
package dwt_pkg;

  localparam int SCALE  = 181;
  localparam int SHIFT  = 8;
  localparam int ROUND  = 128;
  localparam int MAX_DW = 24;
  localparam int WIDE_W = MAX_DW + 10;

  typedef enum logic [0:0] {
    ST_EVEN = 1'b0,
    ST_ODD  = 1'b1
  } asm_state_e;

  // Samples are carried sign-extended to MAX_DW so one type serves every DW.
  typedef struct packed {
    logic [MAX_DW-1:0] x0;
    logic [MAX_DW-1:0] x1;
    logic              last;
    logic              pad;
  } pair_t;

  // Clamp v into [-2^(dw-1), 2^(dw-1)-1]; a result differing from v means saturation.
  function automatic logic signed [WIDE_W-1:0] sat_to_dw(
    input logic signed [WIDE_W-1:0] v,
    input int unsigned              dw
  );
    logic signed [WIDE_W-1:0] one_v;
    logic signed [WIDE_W-1:0] hi_v;
    logic signed [WIDE_W-1:0] lo_v;
    logic signed [WIDE_W-1:0] res_v;
    one_v = 34'sd1;
    hi_v  = (one_v <<< (dw - 32'd1)) - one_v;
    lo_v  = -hi_v - one_v;
    if (v > hi_v) begin
      res_v = hi_v;
    end else if (v < lo_v) begin
      res_v = lo_v;
    end else begin
      res_v = v;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/dwt_haar_pair_core.sv
// Arithmetic pipeline for one Haar pair: S2 (sum/difference), S3 (scaled and
// rounded products), then the saturated output register.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  global advance enable; every stage holds when low
//   in_vld, in_pair     assembled pair from the S1 register
//   out_vld, out_ca,
//   out_cd, out_last,
//   out_pad             registered coefficient pair and framing flags
//   sat_ca, sat_cd      a saturated coefficient is entering the output register
module dwt_haar_pair_core
  import dwt_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_vld,
  input  pair_t         in_pair,
  output logic          out_vld,
  output logic [DW-1:0] out_ca,
  output logic [DW-1:0] out_cd,
  output logic          out_last,
  output logic          out_pad,
  output logic          sat_ca,
  output logic          sat_cd
);

  localparam int SW = DW + 1;
  localparam int PW = DW + 10;
  localparam logic signed [PW-1:0] SCALE_K = PW'(SCALE);
  localparam logic signed [PW-1:0] ROUND_K = PW'(ROUND);

  logic signed [MAX_DW:0]   x0_ext_s;
  logic signed [MAX_DW:0]   x1_ext_s;
  logic signed [SW-1:0]     s2_s_r;
  logic signed [SW-1:0]     s2_d_r;
  logic                     s2_vld_r;
  logic                     s2_last_r;
  logic                     s2_pad_r;
  logic signed [PW-1:0]     p_s;
  logic signed [PW-1:0]     q_s;
  logic signed [PW-1:0]     s3_ca_r;
  logic signed [PW-1:0]     s3_cd_r;
  logic                     s3_vld_r;
  logic                     s3_last_r;
  logic                     s3_pad_r;
  logic signed [WIDE_W-1:0] ca_wide_s;
  logic signed [WIDE_W-1:0] cd_wide_s;
  logic signed [WIDE_W-1:0] ca_clip_s;
  logic signed [WIDE_W-1:0] cd_clip_s;

  // One guard bit so the sum/difference of two DW-bit samples never overflows.
  assign x0_ext_s = $signed({in_pair.x0[MAX_DW-1], in_pair.x0});
  assign x1_ext_s = $signed({in_pair.x1[MAX_DW-1], in_pair.x1});

  // S2: sum and difference of the pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_r  <= 1'b0;
      s2_s_r    <= {SW{1'b0}};
      s2_d_r    <= {SW{1'b0}};
      s2_last_r <= 1'b0;
      s2_pad_r  <= 1'b0;
    end else if (en) begin
      s2_vld_r  <= in_vld;
      s2_s_r    <= SW'(x0_ext_s + x1_ext_s);
      s2_d_r    <= SW'(x0_ext_s - x1_ext_s);
      s2_last_r <= in_pair.last;
      s2_pad_r  <= in_pair.pad;
    end
  end

  // Scale by 181/256; DW+1 bits times a 9-bit signed constant fits in DW+10.
  always_comb begin
    p_s = PW'(s2_s_r) * SCALE_K;
    q_s = PW'(s2_d_r) * SCALE_K;
  end

  // S3: add half an LSB and floor-shift, giving round-half-up toward +inf.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_vld_r  <= 1'b0;
      s3_ca_r   <= {PW{1'b0}};
      s3_cd_r   <= {PW{1'b0}};
      s3_last_r <= 1'b0;
      s3_pad_r  <= 1'b0;
    end else if (en) begin
      s3_vld_r  <= s2_vld_r;
      s3_ca_r   <= (p_s + ROUND_K) >>> SHIFT;
      s3_cd_r   <= (q_s + ROUND_K) >>> SHIFT;
      s3_last_r <= s2_last_r;
      s3_pad_r  <= s2_pad_r;
    end
  end

  // Clamp to DW bits; any change made by the clamp is a saturation event.
  always_comb begin
    ca_wide_s = WIDE_W'(s3_ca_r);
    cd_wide_s = WIDE_W'(s3_cd_r);
    ca_clip_s = sat_to_dw(ca_wide_s, DW);
    cd_clip_s = sat_to_dw(cd_wide_s, DW);
    sat_ca    = en && s3_vld_r && (ca_clip_s != ca_wide_s);
    sat_cd    = en && s3_vld_r && (cd_clip_s != cd_wide_s);
  end

  // Output register: holds the pair stable while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_ca   <= {DW{1'b0}};
      out_cd   <= {DW{1'b0}};
      out_last <= 1'b0;
      out_pad  <= 1'b0;
    end else if (en) begin
      out_vld  <= s3_vld_r;
      out_ca   <= ca_clip_s[DW-1:0];
      out_cd   <= cd_clip_s[DW-1:0];
      out_last <= s3_last_r;
      out_pad  <= s3_pad_r;
    end
  end

endmodule

// File: rtl/dwt_haar_stream.sv
// Streaming single-level Haar DWT: pairs up a framed sample stream and emits
// one (cA, cD) pair per two samples; a lone final sample is paired with itself.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/
//   in_last                       sample input handshake, frame delimiter
//   out_valid/out_ready/out_ca/
//   out_cd/out_last/out_pad       coefficient output handshake and flags
//   sat_clr                       synchronous clear of sat_cnt (wins over increments)
//   sat_cnt                       count of saturated coefficients, sticky at all-ones
module dwt_haar_stream
  import dwt_pkg::*;
#(
  parameter int DW        = 16,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_ca,
  output logic [DW-1:0]        out_cd,
  output logic                 out_last,
  output logic                 out_pad,
  input  logic                 sat_clr,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  asm_state_e           state_r;
  asm_state_e           state_nxt_s;
  logic [DW-1:0]        x0_r;
  logic                 x0_load_s;
  logic                 en_s;
  logic                 accept_s;
  logic [MAX_DW-1:0]    in_ext_s;
  logic [MAX_DW-1:0]    x0_ext_s;
  logic                 pair_vld_s;
  pair_t                pair_s;
  logic                 s1_vld_r;
  pair_t                s1_pair_r;
  logic                 sat_ca_s;
  logic                 sat_cd_s;
  logic [SAT_CNT_W:0]   sat_sum_s;

  // The whole pipeline advances together, so the input is ready exactly when
  // the output register is empty or being drained this cycle.
  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s;
  assign accept_s = in_valid && en_s;
  assign in_ext_s = MAX_DW'($signed(in_data));
  assign x0_ext_s = MAX_DW'($signed(x0_r));

  // Assembler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EVEN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Assembler next state and pair issue.
  always_comb begin
    state_nxt_s = state_r;
    pair_vld_s  = 1'b0;
    pair_s      = {$bits(pair_t){1'b0}};
    x0_load_s   = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_EVEN: begin
          if (in_last) begin
            // Odd-length frame: duplicate the lone sample so cD comes out 0.
            pair_vld_s  = 1'b1;
            pair_s.x0   = in_ext_s;
            pair_s.x1   = in_ext_s;
            pair_s.last = 1'b1;
            pair_s.pad  = 1'b1;
            state_nxt_s = ST_EVEN;
          end else begin
            x0_load_s   = 1'b1;
            state_nxt_s = ST_ODD;
          end
        end
        ST_ODD: begin
          pair_vld_s  = 1'b1;
          pair_s.x0   = x0_ext_s;
          pair_s.x1   = in_ext_s;
          pair_s.last = in_last;
          pair_s.pad  = 1'b0;
          state_nxt_s = ST_EVEN;
        end
        default: begin
          state_nxt_s = ST_EVEN;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // First sample of a pair; kept for as long as the partner takes to arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_r <= {DW{1'b0}};
    end else if (x0_load_s) begin
      x0_r <= in_data;
    end else begin
      x0_r <= x0_r;
    end
  end

  // S1: assembled pair register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_r  <= 1'b0;
      s1_pair_r <= {$bits(pair_t){1'b0}};
    end else if (en_s) begin
      s1_vld_r  <= pair_vld_s;
      s1_pair_r <= pair_s;
    end
  end

  dwt_haar_pair_core #(
    .DW (DW)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (en_s),
    .in_vld   (s1_vld_r),
    .in_pair  (s1_pair_r),
    .out_vld  (out_valid),
    .out_ca   (out_ca),
    .out_cd   (out_cd),
    .out_last (out_last),
    .out_pad  (out_pad),
    .sat_ca   (sat_ca_s),
    .sat_cd   (sat_cd_s)
  );

  // Extra top bit catches the carry so the counter can stick at all-ones.
  assign sat_sum_s = {1'b0, sat_cnt} + (SAT_CNT_W+1)'(sat_ca_s) + (SAT_CNT_W+1)'(sat_cd_s);

  // Saturation event counter; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= {SAT_CNT_W{1'b0}};
    end else if (sat_clr) begin
      sat_cnt <= {SAT_CNT_W{1'b0}};
    end else if (sat_sum_s[SAT_CNT_W]) begin
      sat_cnt <= {SAT_CNT_W{1'b1}};
    end else begin
      sat_cnt <= sat_sum_s[SAT_CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_dwt_haar_stream.sv
// Self-checking bench for dwt_haar_stream (DW=16): directed vectors with
// literal expectations plus a pair-level reference model and scoreboard.
module tb_dwt_haar_stream;

  localparam int DW  = 16;
  localparam int SCW = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic signed [DW-1:0]  in_data = 16'sd0;
  logic                  in_last = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic signed [DW-1:0]  out_ca;
  logic signed [DW-1:0]  out_cd;
  logic                  out_last;
  logic                  out_pad;
  logic                  sat_clr = 1'b0;
  logic [SCW-1:0]        sat_cnt;

  typedef struct {
    int ca;
    int cd;
    bit last;
    bit pad;
  } coef_t;

  coef_t exp_q[$];
  coef_t got_q[$];
  coef_t e_v;
  coef_t g_v;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int first_out_cyc = -1;
  int last_acc_edge = 0;
  int n_exp = 0;
  int n_out = 0;
  bit have_x0 = 1'b0;
  int x0_v = 0;
  bit saw_low = 1'b0;
  bit hold_v = 1'b0;
  logic [34:0] hold_vec = 35'd0;

  dwt_haar_stream #(
    .DW        (DW),
    .SAT_CNT_W (SCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ca    (out_ca),
    .out_cd    (out_cd),
    .out_last  (out_last),
    .out_pad   (out_pad),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  // Cycle counter, read at negedges for latency measurement.
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint got, input longint req);
    n_chk++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Haar coefficient straight from the definition: floor((v*181+128)/256), clamped.
  function automatic int coef(input int a, input int b, input bit diff);
    int v;
    int r;
    v = diff ? (a - b) : (a + b);
    r = (v * 181 + 128) >>> 8;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic coef_t mk_pair(input int a, input int b, input bit last, input bit pad);
    coef_t c;
    c.ca = coef(a, b, 1'b0);
    c.cd = coef(a, b, 1'b1);
    c.last = last;
    c.pad = pad;
    return c;
  endfunction

  // Downstream ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor/model/scoreboard, sampled at the inactive edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      have_x0 = 1'b0;
      hold_v = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (!in_ready) saw_low = 1'b1;
      if (hold_v) check("hold_stable", {out_valid, out_ca, out_cd, out_last, out_pad}, hold_vec);
      hold_v = out_valid && !out_ready;
      hold_vec = {out_valid, out_ca, out_cd, out_last, out_pad};
      if (out_valid && out_ready) begin
        n_out++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        g_v.ca = out_ca;
        g_v.cd = out_cd;
        g_v.last = out_last;
        g_v.pad = out_pad;
        got_q.push_back(g_v);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_pair: got ca=%0d cd=%0d, required no pair", g_v.ca, g_v.cd);
        end else begin
          e_v = exp_q.pop_front();
          check("sb_ca", g_v.ca, e_v.ca);
          check("sb_cd", g_v.cd, e_v.cd);
          check("sb_last", g_v.last, e_v.last);
          check("sb_pad", g_v.pad, e_v.pad);
        end
      end
      if (in_valid && in_ready) begin
        last_acc_edge = cyc + 1;
        if (!have_x0) begin
          if (in_last) begin
            exp_q.push_back(mk_pair(int'(in_data), int'(in_data), 1'b1, 1'b1));
            n_exp++;
          end else begin
            x0_v = in_data;
            have_x0 = 1'b1;
          end
        end else begin
          exp_q.push_back(mk_pair(x0_v, int'(in_data), in_last, 1'b0));
          n_exp++;
          have_x0 = 1'b0;
        end
      end
    end
  end

  // Present one sample and hold it until accepted; returns at posedge+1.
  task automatic send(input int x, input bit last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data = 16'(x);
    in_last = last;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("accept_timeout", (guard < 1000), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // Wait until every modelled pair has left the DUT.
  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("drain_timeout", (g < 3000), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pair(input string name, input int idx, input int ca, input int cd,
                             input bit last, input bit pad);
    if (got_q.size() <= idx) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_missing: got %0d pairs, required more than %0d", name, got_q.size(), idx);
    end else begin
      check({name, "_ca"}, got_q[idx].ca, ca);
      check({name, "_cd"}, got_q[idx].cd, cd);
      check({name, "_last"}, got_q[idx].last, last);
      check({name, "_pad"}, got_q[idx].pad, pad);
    end
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog expired");
  end

  // Main directed sequence.
  initial begin
    int base_out;
    int base_exp;
    int len;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_ca", out_ca, 0);
    check("rst_out_cd", out_cd, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_pad", out_pad, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 100,100 -> 141,0 with 3-cycle latency.
    got_q.delete();
    first_out_cyc = -1;
    send(100, 1'b0);
    send(100, 1'b1);
    drain();
    check("t1_count", got_q.size(), 1);
    expect_pair("t1", 0, 141, 0, 1'b1, 1'b0);
    check("t1_latency", first_out_cyc - last_acc_edge, 3);

    // -100,100 -> 0,-141.
    got_q.delete();
    send(-100, 1'b0);
    send(100, 1'b1);
    drain();
    expect_pair("t2", 0, 0, -141, 1'b1, 1'b0);

    // Odd frame 10,20,30.
    got_q.delete();
    send(10, 1'b0);
    send(20, 1'b0);
    send(30, 1'b1);
    drain();
    check("t3_count", got_q.size(), 2);
    expect_pair("t3a", 0, 21, -7, 1'b0, 1'b0);
    expect_pair("t3b", 1, 42, 0, 1'b1, 1'b1);

    // Saturation counter.
    got_q.delete();
    send(32767, 1'b0);
    send(32767, 1'b1);
    drain();
    expect_pair("sat_hi", 0, 32767, 0, 1'b1, 1'b0);
    check("sat_cnt_1", sat_cnt, 1);
    send(-32768, 1'b0);
    send(-32768, 1'b1);
    drain();
    expect_pair("sat_lo", 1, -32768, 0, 1'b1, 1'b0);
    check("sat_cnt_2", sat_cnt, 2);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    check("sat_cnt_clr", sat_cnt, 0);

    // Backpressure: 16-sample frame with a 10-cycle downstream stall.
    got_q.delete();
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 16; i++) send(int'($urandom_range(0, 65535)), (i == 15));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 2;
        repeat (10) @(posedge clk);
        #1;
        rdy_mode = 0;
      end
    join
    drain();
    check("bp_count", got_q.size(), 8);
    check("bp_in_ready_fell", saw_low, 1);

    // Random ready over 1000 mixed-length frames.
    rdy_mode = 1;
    base_out = n_out;
    base_exp = n_exp;
    for (int f = 0; f < 1000; f++) begin
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send(int'($urandom_range(0, 65535)), (i == len - 1));
      end
    end
    drain();
    rdy_mode = 0;
    check("rand_no_loss", n_out - base_out, n_exp - base_exp);
    check("rand_q_empty", exp_q.size(), 0);

    // Reset mid-frame with a pair in flight and x0 held.
    send(1, 1'b0);
    send(2, 1'b0);
    send(9, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst2_sat_cnt", sat_cnt, 0);
    check("rst2_out_valid", out_valid, 0);
    got_q.delete();
    send(5, 1'b0);
    send(7, 1'b1);
    drain();
    check("rst2_count", got_q.size(), 1);
    expect_pair("rst2", 0, 8, -1, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
